// File: rtl/debug_probe_pkg.sv
// Shared state encoding, timestamp width and a clog2 helper for the debug probe capture block.
package debug_probe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } state_e;

  localparam int TS_W = 16;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/debug_probe_ram.sv
// Simple dual-port sample RAM with one write port and a registered read port (1-cycle latency).
module debug_probe_ram
  import debug_probe_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int W     = 32,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] rdata_q;

  // No reset on the array or read register so the tools can map this onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/debug_probe_capture.sv
// Probe capture with masked/external trigger, programmable pre-trigger depth and frozen readout.
// Define PROBE_CAP_TIMESTAMP_EN to prepend a 16-bit cycle timestamp to every stored sample.
module debug_probe_capture
  import debug_probe_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = clog2_f(DEPTH)
) (
  input  logic                     clk16x,
  input  logic                     reset_n,
  input  logic [NUM_CH*CH_W-1:0]   probe_in,
  input  logic                     probe_vld,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [NUM_CH*CH_W-1:0]   trig_mask,
  input  logic [NUM_CH*CH_W-1:0]   trig_value,
  input  logic                     trig_ext,
  input  logic [AW-1:0]            pretrig,
  input  logic                     rd_req,
`ifdef PROBE_CAP_TIMESTAMP_EN
  output logic [NUM_CH*CH_W+TS_W-1:0] rd_data,
`else
  output logic [NUM_CH*CH_W-1:0]   rd_data,
`endif
  output logic                     rd_valid,
  output logic                     rd_last,
  output logic                     busy,
  output logic                     triggered,
  output logic                     done
);

  localparam int DW = NUM_CH * CH_W;
`ifdef PROBE_CAP_TIMESTAMP_EN
  localparam int RW = DW + TS_W;
`else
  localparam int RW = DW;
`endif
  localparam logic [AW:0] DEPTH_M1 = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] pt_q, pt_d;
  logic [AW-1:0] pre_left_q, pre_left_d;
  logic [AW:0]   post_cnt_q, post_cnt_d;
  logic [AW:0]   rd_cnt_q, rd_cnt_d;
  logic          triggered_q, triggered_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;

  logic          wr_en;
  logic          rd_en;
  logic          trig_hit;
  logic [RW-1:0] wr_data;
  logic [RW-1:0] ram_rdata;

  assign trig_hit = trig_ext | (((probe_in ^ trig_value) & trig_mask) == '0);

`ifdef PROBE_CAP_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q, ts_d;

  always_comb begin
    ts_d = arm ? '0 : ts_q + TS_W'(1);
  end

  always_ff @(posedge clk16x or negedge reset_n) begin
    if (!reset_n) ts_q <= '0;
    else          ts_q <= ts_d;
  end

  assign wr_data = {ts_q, probe_in};
`else
  assign wr_data = probe_in;
`endif

  // abort outranks arm, and both outrank whatever the current state would do.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pt_d        = pt_q;
    pre_left_d  = pre_left_q;
    post_cnt_d  = post_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    triggered_d = triggered_q;
    wr_en       = 1'b0;
    rd_en       = 1'b0;

    if (abort) begin
      state_d     = ST_IDLE;
      triggered_d = 1'b0;
    end else if (arm) begin
      state_d     = (pretrig == '0) ? ST_ARMED : ST_PRE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pt_d        = pretrig;
      pre_left_d  = pretrig;
      post_cnt_d  = '0;
      rd_cnt_d    = '0;
      triggered_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_PRE: begin
          if (probe_vld) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
            pre_left_d = pre_left_q - AW'(1);
            if (pre_left_q == AW'(1)) state_d = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (probe_vld) begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (trig_hit) begin
              triggered_d = 1'b1;
              // The trigger sample itself is the first of the DEPTH - pt post samples.
              post_cnt_d  = DEPTH_M1 - {1'b0, pt_q};
              if (post_cnt_d == '0) begin
                state_d  = ST_DONE;
                rd_ptr_d = wr_ptr_d;
              end else begin
                state_d = ST_POST;
              end
            end
          end
        end
        ST_POST: begin
          if (probe_vld) begin
            wr_en      = 1'b1;
            wr_ptr_d   = wr_ptr_q + AW'(1);
            post_cnt_d = post_cnt_q - (AW+1)'(1);
            if (post_cnt_q == (AW+1)'(1)) begin
              state_d  = ST_DONE;
              rd_ptr_d = wr_ptr_d;
            end
          end
        end
        ST_DONE: begin
          if (rd_req && (rd_cnt_q != CNT_FULL)) begin
            rd_en    = 1'b1;
            rd_ptr_d = rd_ptr_q + AW'(1);
            rd_cnt_d = rd_cnt_q + (AW+1)'(1);
          end
        end
        default: ;
      endcase
    end

    busy_d     = (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
    done_d     = (state_d == ST_DONE);
    rd_valid_d = rd_en;
    rd_last_d  = rd_en && (rd_cnt_q == DEPTH_M1);
  end

  always_ff @(posedge clk16x or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pt_q        <= '0;
      pre_left_q  <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      triggered_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pt_q        <= pt_d;
      pre_left_q  <= pre_left_d;
      post_cnt_q  <= post_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      triggered_q <= triggered_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
    end
  end

  debug_probe_ram #(
    .DEPTH (DEPTH),
    .W     (RW),
    .AW    (AW)
  ) u_ram (
    .clk   (clk16x),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_ptr_q),
    .rdata (ram_rdata)
  );

  // The RAM read register has no reset, so gate it to keep rd_data at zero outside a valid beat.
  assign rd_data   = rd_valid_q ? ram_rdata : '0;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign busy      = busy_q;
  assign triggered = triggered_q;
  assign done      = done_q;

endmodule

// File: tb/tb_debug_probe_capture.sv
// Directed bench for debug_probe_capture at NUM_CH=4, CH_W=8, DEPTH=16.
module tb_debug_probe_capture;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 8;
  localparam int DEPTH  = 16;
  localparam int AW     = 4;
  localparam int DW     = NUM_CH * CH_W;
`ifdef PROBE_CAP_TIMESTAMP_EN
  localparam int RW = DW + 16;
`else
  localparam int RW = DW;
`endif

  logic          clk16x = 1'b0;
  logic          reset_n;
  logic [DW-1:0] probe_in;
  logic          probe_vld;
  logic          arm;
  logic          abort;
  logic [DW-1:0] trig_mask;
  logic [DW-1:0] trig_value;
  logic          trig_ext;
  logic [AW-1:0] pretrig;
  logic          rd_req;
  logic [RW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic          busy;
  logic          triggered;
  logic          done;

  int checks = 0;
  int errors = 0;

  debug_probe_capture #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk16x     (clk16x),
    .reset_n    (reset_n),
    .probe_in   (probe_in),
    .probe_vld  (probe_vld),
    .arm        (arm),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_ext   (trig_ext),
    .pretrig    (pretrig),
    .rd_req     (rd_req),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done)
  );

  always #5 clk16x = ~clk16x;

  task automatic tick();
    @(posedge clk16x);
    #1;
  endtask

  task automatic do_arm(input logic [AW-1:0] pt, input logic [DW-1:0] mask, input logic [DW-1:0] value);
    trig_mask  = mask;
    trig_value = value;
    pretrig    = pt;
    arm        = 1'b1;
    tick();
    arm        = 1'b0;
  endtask

  // Feeds samples start..stop-1 (or until done rises); sample j is base+j except spec_idx.
  task automatic run_capture(input logic [DW-1:0] base, input int start, input int stop,
                             input int spec_idx, input logic [DW-1:0] spec_val,
                             input bit gaps, output int n_fed);
    n_fed = start;
    while (n_fed < stop && !done) begin
      probe_in  = (n_fed == spec_idx) ? spec_val : base + DW'(n_fed);
      probe_vld = 1'b1;
      tick();
      n_fed++;
      probe_vld = 1'b0;
      if (gaps && !done) tick();
    end
    probe_vld = 1'b0;
  endtask

  // Reads the frozen buffer; read k must equal sample first+k, with rd_last only on read 16.
  task automatic read_check(input string name, input logic [DW-1:0] base, input int first,
                            input int spec_idx, input logic [DW-1:0] spec_val);
    logic [DW-1:0] exp;
    for (int k = 0; k < DEPTH; k++) begin
      exp    = ((first + k) == spec_idx) ? spec_val : base + DW'(first + k);
      rd_req = 1'b1;
      tick();
      checks++;
      if (rd_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL %s rd_valid read %0d: got %b expected 1", name, k, rd_valid);
      end
      checks++;
      if (rd_data[DW-1:0] !== exp) begin
        errors++;
        $display("[TB] FAIL %s rd_data read %0d: got %h expected %h", name, k, rd_data[DW-1:0], exp);
      end
      checks++;
      if (rd_last !== (k == DEPTH - 1)) begin
        errors++;
        $display("[TB] FAIL %s rd_last read %0d: got %b expected %b", name, k, rd_last, (k == DEPTH - 1));
      end
    end
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s extra rd_req: rd_valid got %b expected 0", name, rd_valid);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({busy, triggered, done, rd_valid, rd_last} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000", {busy, triggered, done, rd_valid, rd_last});
    end
    reset_n = 1'b1;
    tick();
    rd_req = 1'b1;
    tick();
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_rd_req: rd_valid got %b expected 0", rd_valid);
    end
    rd_req = 1'b0;
  endtask

  task automatic test_pretrig_capture();
    int n;
    do_arm(4'd4, 32'hFF00_0000, 32'hA500_0000);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pretrig_busy: got %b expected 1", busy);
    end
    run_capture(32'h0, 0, 60, 10, 32'hA500_000A, 1'b0, n);
    checks++;
    if (n !== 22 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pretrig_done: samples %0d done %b expected 22 and 1", n, done);
    end
    checks++;
    if (triggered !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pretrig_flags: triggered %b busy %b expected 1 0", triggered, busy);
    end
    read_check("pretrig", 32'h0, 6, 10, 32'hA500_000A);
  endtask

  task automatic test_zero_pretrig();
    int n;
    do_arm(4'd0, 32'h0, 32'h1234_5678);
    run_capture(32'hC0DE_0000, 0, 60, -1, 32'h0, 1'b1, n);
    checks++;
    if (n !== 16 || done !== 1'b1 || triggered !== 1'b1) begin
      errors++;
      $display("[TB] FAIL zero_pretrig_done: samples %0d done %b trig %b expected 16 1 1", n, done, triggered);
    end
    read_check("zero_pretrig", 32'hC0DE_0000, 0, -1, 32'h0);
  endtask

  task automatic test_ext_trigger();
    int n;
    do_arm(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_capture(32'h0E00_0000, 0, 3, -1, 32'h0, 1'b0, n);
    trig_ext = 1'b1;
    tick();
    trig_ext = 1'b0;
    tick();
    checks++;
    if (triggered !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ext_no_vld: triggered %b busy %b expected 0 1", triggered, busy);
    end
    run_capture(32'h0E00_0000, 3, 4, -1, 32'h0, 1'b0, n);
    trig_ext = 1'b1;
    run_capture(32'h0E00_0000, 4, 5, -1, 32'h0, 1'b0, n);
    trig_ext = 1'b0;
    checks++;
    if (triggered !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ext_with_vld: triggered got %b expected 1", triggered);
    end
    run_capture(32'h0E00_0000, 5, 60, -1, 32'h0, 1'b0, n);
    checks++;
    if (n !== 18 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ext_done: samples %0d done %b expected 18 and 1", n, done);
    end
    read_check("ext", 32'h0E00_0000, 2, -1, 32'h0);
  endtask

  task automatic test_abort();
    int n;
    do_arm(4'd0, 32'h0, 32'h0);
    run_capture(32'h0, 0, 3, -1, 32'h0, 1'b0, n);
    checks++;
    if (triggered !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre: triggered %b busy %b expected 1 1", triggered, busy);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({busy, done, triggered} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_flags: got %b expected 000", {busy, done, triggered});
    end
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL abort_rd_req: rd_valid got %b expected 0", rd_valid);
    end
    arm   = 1'b1;
    abort = 1'b1;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    probe_vld = 1'b1;
    tick();
    probe_vld = 1'b0;
    checks++;
    if ({busy, triggered, done} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL arm_abort_same: got %b expected 000", {busy, triggered, done});
    end
  endtask

  task automatic test_reset_mid_post();
    int n;
    do_arm(4'd0, 32'h0, 32'h0);
    run_capture(32'h0, 0, 3, -1, 32'h0, 1'b0, n);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, triggered, done, rd_valid, rd_last} !== 5'b0 || rd_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_post: flags %b data %h expected 00000 and 0",
               {busy, triggered, done, rd_valid, rd_last}, rd_data);
    end
    reset_n = 1'b1;
    tick();
    do_arm(4'd3, 32'h0, 32'h0);
    run_capture(32'h5A00_0100, 0, 60, -1, 32'h0, 1'b0, n);
    checks++;
    if (n !== 16 || done !== 1'b1 || triggered !== 1'b1) begin
      errors++;
      $display("[TB] FAIL after_reset_done: samples %0d done %b trig %b expected 16 1 1", n, done, triggered);
    end
    read_check("after_reset", 32'h5A00_0100, 0, -1, 32'h0);
  endtask

`ifdef PROBE_CAP_TIMESTAMP_EN
  task automatic test_timestamp();
    int n;
    logic [15:0] prev_ts;
    do_arm(4'd0, 32'h0, 32'h0);
    run_capture(32'h7700_0000, 0, 60, -1, 32'h0, 1'b1, n);
    prev_ts = '0;
    for (int k = 0; k < DEPTH; k++) begin
      rd_req = 1'b1;
      tick();
      checks++;
      if (k == 0 && rd_data[RW-1:DW] > 16'd1) begin
        errors++;
        $display("[TB] FAIL ts_first: got %0d expected 0 or 1", rd_data[RW-1:DW]);
      end else if (k != 0 && rd_data[RW-1:DW] !== prev_ts + 16'd2) begin
        errors++;
        $display("[TB] FAIL ts_step read %0d: got %0d expected %0d", k, rd_data[RW-1:DW], prev_ts + 16'd2);
      end
      prev_ts = rd_data[RW-1:DW];
    end
    rd_req = 1'b0;
    tick();
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    probe_in   = '0;
    probe_vld  = 1'b0;
    arm        = 1'b0;
    abort      = 1'b0;
    trig_mask  = '0;
    trig_value = '0;
    trig_ext   = 1'b0;
    pretrig    = '0;
    rd_req     = 1'b0;

    test_reset();
    test_pretrig_capture();
    test_zero_pretrig();
    test_ext_trigger();
    test_abort();
    test_reset_mid_post();
`ifdef PROBE_CAP_TIMESTAMP_EN
    test_timestamp();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
